// File: rtl/ptp_up_reg_slave.sv
// ptp_up_reg_slave
// Register-bank responder for the up_* CPU bus of the PTP block. Holds the
// RTC control/period/load registers, an atomic TOD snapshot of the live RTC,
// the timestamp-queue pop/shadow logic and the interrupt status/mask pair.
//
// Ports
//   up_clk, up_rst        clock, synchronous active-high reset
//   up_wr, up_rd          one-cycle write / read strobes (may coincide)
//   up_addr               byte address, bits [1:0] ignored
//   up_data_wr            write data
//   up_data_rd            registered read data, held until the next read
//   rtc_time_in           live RTC time {sec[47:0], ns[31:0]}
//   rtc_en                CTRL[0]
//   rtc_period            PERIOD register
//   rtc_load_time         {LOAD_SEC_HI, LOAD_SEC_LO, 2'b0, LOAD_NS}
//   rtc_load              one-cycle load pulse after a CMD[1] write
//   ts_q_empty, ts_q_data timestamp queue status and head entry
//   ts_q_pop              one-cycle pop pulse after a TSQ_SEC_HI read
//   evt_in                level event sources feeding IRQ_STAT
//   irq                   registered OR of IRQ_STAT & IRQ_MASK
module ptp_up_reg_slave #(
  parameter logic [31:0] ID_VALUE   = 32'h5054_5031,
  parameter logic [31:0] PERIOD_RST = 32'h0800_0000
) (
  input  logic        up_clk,
  input  logic        up_rst,
  input  logic        up_wr,
  input  logic        up_rd,
  input  logic [7:0]  up_addr,
  input  logic [31:0] up_data_wr,
  output logic [31:0] up_data_rd,
  input  logic [79:0] rtc_time_in,
  output logic        rtc_en,
  output logic [31:0] rtc_period,
  output logic [79:0] rtc_load_time,
  output logic        rtc_load,
  input  logic        ts_q_empty,
  input  logic [79:0] ts_q_data,
  output logic        ts_q_pop,
  input  logic [3:0]  evt_in,
  output logic        irq
);

  // Word indices (byte address >> 2)
  localparam logic [5:0] A_CTRL       = 6'h00;
  localparam logic [5:0] A_CMD        = 6'h01;
  localparam logic [5:0] A_PERIOD     = 6'h02;
  localparam logic [5:0] A_LOAD_SHI   = 6'h04;
  localparam logic [5:0] A_LOAD_SLO   = 6'h05;
  localparam logic [5:0] A_LOAD_NS    = 6'h06;
  localparam logic [5:0] A_TOD_SHI    = 6'h08;
  localparam logic [5:0] A_TOD_SLO    = 6'h09;
  localparam logic [5:0] A_TOD_NS     = 6'h0A;
  localparam logic [5:0] A_TSQ_STAT   = 6'h0C;
  localparam logic [5:0] A_TSQ_SHI    = 6'h0D;
  localparam logic [5:0] A_TSQ_SLO    = 6'h0E;
  localparam logic [5:0] A_TSQ_NS     = 6'h0F;
  localparam logic [5:0] A_IRQ_STAT   = 6'h10;
  localparam logic [5:0] A_IRQ_MASK   = 6'h11;
  localparam logic [5:0] A_SCRATCH    = 6'h12;
  localparam logic [5:0] A_ID         = 6'h3F;

  logic        r_ctrl_en;
  logic [31:0] r_period;
  logic [15:0] r_load_sec_hi;
  logic [31:0] r_load_sec_lo;
  logic [29:0] r_load_ns;
  logic [79:0] r_tod;
  logic [79:0] r_tsq;
  logic [3:0]  r_irq_stat;
  logic [3:0]  r_irq_mask;
  logic [31:0] r_scratch;
  logic [31:0] r_data_rd;
  logic        r_load;
  logic        r_pop;
  logic        r_irq;

  logic [5:0]  w_idx;
  logic        w_wr_cmd;
  logic        w_tsq_pop;
  logic [3:0]  w_irq_clr;
  logic [31:0] w_rd_data;
  logic        w_unused_ok;

  assign w_idx       = up_addr[7:2];
  assign w_unused_ok = ^up_addr[1:0];
  assign w_wr_cmd    = up_wr && (w_idx == A_CMD);
  // Pop only when there is something to pop; an empty-queue read is inert.
  assign w_tsq_pop   = up_rd && (w_idx == A_TSQ_SHI) && !ts_q_empty;
  assign w_irq_clr   = (up_wr && (w_idx == A_IRQ_STAT)) ? up_data_wr[3:0] : 4'h0;

  // Read mux over the current (pre-write, pre-snapshot) register contents
  always_comb begin
    w_rd_data = 32'h0;
    case (w_idx)
      A_CTRL:     w_rd_data = {31'h0, r_ctrl_en};
      A_PERIOD:   w_rd_data = r_period;
      A_LOAD_SHI: w_rd_data = {16'h0, r_load_sec_hi};
      A_LOAD_SLO: w_rd_data = r_load_sec_lo;
      A_LOAD_NS:  w_rd_data = {2'b00, r_load_ns};
      A_TOD_SHI:  w_rd_data = {16'h0, r_tod[79:64]};
      A_TOD_SLO:  w_rd_data = r_tod[63:32];
      A_TOD_NS:   w_rd_data = r_tod[31:0];
      A_TSQ_STAT: w_rd_data = {31'h0, !ts_q_empty};
      A_TSQ_SHI: begin
        if (!ts_q_empty) begin
          w_rd_data = {16'h0, ts_q_data[79:64]};
        end else begin
          w_rd_data = 32'h0;
        end
      end
      A_TSQ_SLO:  w_rd_data = r_tsq[63:32];
      A_TSQ_NS:   w_rd_data = r_tsq[31:0];
      A_IRQ_STAT: w_rd_data = {28'h0, r_irq_stat};
      A_IRQ_MASK: w_rd_data = {28'h0, r_irq_mask};
      A_SCRATCH:  w_rd_data = r_scratch;
      A_ID:       w_rd_data = ID_VALUE;
      default:    w_rd_data = 32'h0;
    endcase
  end

  // Writable configuration registers
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_ctrl_en     <= 1'b0;
      r_period      <= PERIOD_RST;
      r_load_sec_hi <= 16'h0;
      r_load_sec_lo <= 32'h0;
      r_load_ns     <= 30'h0;
      r_irq_mask    <= 4'h0;
      r_scratch     <= 32'h0;
    end else if (up_wr) begin
      case (w_idx)
        A_CTRL:     r_ctrl_en     <= up_data_wr[0];
        A_PERIOD:   r_period      <= up_data_wr;
        A_LOAD_SHI: r_load_sec_hi <= up_data_wr[15:0];
        A_LOAD_SLO: r_load_sec_lo <= up_data_wr;
        A_LOAD_NS:  r_load_ns     <= up_data_wr[29:0];
        A_IRQ_MASK: r_irq_mask    <= up_data_wr[3:0];
        A_SCRATCH:  r_scratch     <= up_data_wr;
        default:    r_scratch     <= r_scratch;
      endcase
    end
  end

  // CMD handling: TOD snapshot and the one-cycle RTC load pulse
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_tod  <= 80'h0;
      r_load <= 1'b0;
    end else begin
      if (w_wr_cmd && up_data_wr[0]) begin
        r_tod <= rtc_time_in;
      end
      r_load <= w_wr_cmd && up_data_wr[1];
    end
  end

  // Read data register, TSQ shadow capture and pop pulse
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_data_rd <= 32'h0;
      r_tsq     <= 80'h0;
      r_pop     <= 1'b0;
    end else begin
      if (up_rd) begin
        r_data_rd <= w_rd_data;
      end
      if (w_tsq_pop) begin
        r_tsq <= ts_q_data;
      end
      r_pop <= w_tsq_pop;
    end
  end

  // Interrupt status (event set dominates W1C clear) and registered irq
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_irq_stat <= 4'h0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_irq_clr) | evt_in;
      r_irq      <= |(r_irq_stat & r_irq_mask);
    end
  end

  assign up_data_rd    = r_data_rd;
  assign rtc_en        = r_ctrl_en;
  assign rtc_period    = r_period;
  assign rtc_load_time = {r_load_sec_hi, r_load_sec_lo, 2'b00, r_load_ns};
  assign rtc_load      = r_load;
  assign ts_q_pop      = r_pop;
  assign irq           = r_irq;

endmodule

// File: tb/tb_ptp_up_reg_slave.sv
// Directed + randomized bench for ptp_up_reg_slave against a register-map
// model kept as plain variables and a timestamp queue.
module tb_ptp_up_reg_slave;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        up_wr = 1'b0;
  logic        up_rd = 1'b0;
  logic [7:0]  up_addr = 8'h0;
  logic [31:0] up_data_wr = 32'h0;
  logic [31:0] up_data_rd;
  logic [79:0] rtc_time_in = 80'h0;
  logic        rtc_en;
  logic [31:0] rtc_period;
  logic [79:0] rtc_load_time;
  logic        rtc_load;
  logic        ts_q_empty = 1'b1;
  logic [79:0] ts_q_data = 80'h0;
  logic        ts_q_pop;
  logic [3:0]  evt_in = 4'h0;
  logic        irq;

  ptp_up_reg_slave dut (
    .up_clk(up_clk), .up_rst(up_rst), .up_wr(up_wr), .up_rd(up_rd),
    .up_addr(up_addr), .up_data_wr(up_data_wr), .up_data_rd(up_data_rd),
    .rtc_time_in(rtc_time_in), .rtc_en(rtc_en), .rtc_period(rtc_period),
    .rtc_load_time(rtc_load_time), .rtc_load(rtc_load),
    .ts_q_empty(ts_q_empty), .ts_q_data(ts_q_data), .ts_q_pop(ts_q_pop),
    .evt_in(evt_in), .irq(irq)
  );

  always #5 up_clk = ~up_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  logic [79:0] q[$];
  logic [79:0] rtc;
  logic        m_ctrl;
  logic [31:0] m_period, m_lsl, m_scratch, m_rd;
  logic [15:0] m_lsh;
  logic [29:0] m_lns;
  logic [79:0] m_tod, m_tsq;
  logic [3:0]  m_stat, m_mask;

  logic [7:0] addrs [17] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24,
                             8'h28, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h48, 8'hFC};

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [7:0]  b;
    logic [79:0] h;
    b = {a[7:2], 2'b00};
    h = (q.size() > 0) ? q[0] : 80'h0;
    case (b)
      8'h00: return {31'h0, m_ctrl};
      8'h08: return m_period;
      8'h10: return {16'h0, m_lsh};
      8'h14: return m_lsl;
      8'h18: return {2'b00, m_lns};
      8'h20: return {16'h0, m_tod[79:64]};
      8'h24: return m_tod[63:32];
      8'h28: return m_tod[31:0];
      8'h30: return {31'h0, q.size() > 0};
      8'h34: return (q.size() > 0) ? {16'h0, h[79:64]} : 32'h0;
      8'h38: return m_tsq[63:32];
      8'h3C: return m_tsq[31:0];
      8'h40: return {28'h0, m_stat};
      8'h44: return {28'h0, m_mask};
      8'h48: return m_scratch;
      8'hFC: return 32'h5054_5031;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 1'b0; m_period = 32'h0800_0000; m_lsh = 16'h0; m_lsl = 32'h0;
    m_lns = 30'h0; m_tod = 80'h0; m_tsq = 80'h0; m_stat = 4'h0; m_mask = 4'h0;
    m_scratch = 32'h0; m_rd = 32'h0;
  endtask

  task automatic drive_q();
    ts_q_empty = (q.size() == 0);
    ts_q_data  = (q.size() == 0) ? 80'h0 : q[0];
  endtask

  task automatic check_outputs(input logic exp_pop, input logic exp_load, input logic exp_irq);
    chk("rd_data", {48'h0, up_data_rd}, {48'h0, m_rd});
    chk("ts_q_pop", {79'h0, ts_q_pop}, {79'h0, exp_pop});
    chk("rtc_load", {79'h0, rtc_load}, {79'h0, exp_load});
    chk("irq", {79'h0, irq}, {79'h0, exp_irq});
    chk("rtc_en", {79'h0, rtc_en}, {79'h0, m_ctrl});
    chk("rtc_period", {48'h0, rtc_period}, {48'h0, m_period});
    chk("rtc_load_time", rtc_load_time, {m_lsh, m_lsl, 2'b00, m_lns});
  endtask

  // One bus cycle: drive at negedge, predict, check 1 time unit after posedge.
  task automatic cycle(input logic wr, input logic rd, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] ev);
    logic [7:0] b;
    logic exp_pop, exp_load, exp_irq;
    @(negedge up_clk);
    up_wr = wr; up_rd = rd; up_addr = a; up_data_wr = d; evt_in = ev;
    rtc_time_in = rtc;
    drive_q();
    b = {a[7:2], 2'b00};
    exp_irq  = |(m_stat & m_mask);
    exp_pop  = rd && (b == 8'h34) && (q.size() > 0);
    exp_load = wr && (b == 8'h04) && d[1];
    if (rd) m_rd = m_read(a);
    if (exp_pop) m_tsq = q[0];
    if (wr) begin
      case (b)
        8'h00: m_ctrl = d[0];
        8'h04: if (d[0]) m_tod = rtc;
        8'h08: m_period = d;
        8'h10: m_lsh = d[15:0];
        8'h14: m_lsl = d;
        8'h18: m_lns = d[29:0];
        8'h40: m_stat = m_stat & ~d[3:0];
        8'h44: m_mask = d[3:0];
        8'h48: m_scratch = d;
        default: ;
      endcase
    end
    m_stat = m_stat | ev;
    @(posedge up_clk);
    #1;
    check_outputs(exp_pop, exp_load, exp_irq);
    if (exp_pop) void'(q.pop_front());
  endtask

  task automatic do_reset(input logic rd);
    @(negedge up_clk);
    up_rst = 1'b1; up_wr = 1'b0; up_rd = rd; up_addr = 8'h34; evt_in = 4'h0;
    drive_q();
    @(posedge up_clk);
    #1;
    model_reset();
    check_outputs(1'b0, 1'b0, 1'b0);
    @(negedge up_clk);
    up_rst = 1'b0; up_rd = 1'b0;
  endtask

  initial begin
    rtc = 80'h0;
    model_reset();
    // Reset with a read of a non-empty TSQ_SEC_HI in flight: read dropped, no pop
    q.push_back({16'hBEEF, 32'h1111_2222, 32'h3333_4444});
    do_reset(1'b1);
    do_reset(1'b1);
    chk("reset_q_kept", {79'h0, q.size() == 1}, 80'h1);
    q.delete();

    // Reset state of every map address
    foreach (addrs[i]) cycle(1'b0, 1'b1, addrs[i], 32'h0, 4'h0);
    cycle(1'b0, 1'b1, 8'h08, 32'h0, 4'h0);
    chk("rst_period", {48'h0, up_data_rd}, {48'h0, 32'h0800_0000});
    cycle(1'b0, 1'b1, 8'hFC, 32'h0, 4'h0);
    chk("rst_id", {48'h0, up_data_rd}, {48'h0, 32'h5054_5031});

    // Write/readback
    cycle(1'b1, 1'b0, 8'h48, 32'hA5A5_5A5A, 4'h0);
    cycle(1'b0, 1'b1, 8'h48, 32'h0, 4'h0);
    chk("scratch", {48'h0, up_data_rd}, {48'h0, 32'hA5A5_5A5A});
    cycle(1'b1, 1'b0, 8'h18, 32'hFFFF_FFFF, 4'h0);
    cycle(1'b0, 1'b1, 8'h18, 32'h0, 4'h0);
    chk("load_ns_mask", {48'h0, up_data_rd}, {48'h0, 32'h3FFF_FFFF});
    cycle(1'b1, 1'b0, 8'h80, 32'hDEAD_BEEF, 4'h0);
    cycle(1'b0, 1'b1, 8'h80, 32'h0, 4'h0);
    chk("unmapped", {48'h0, up_data_rd}, 80'h0);
    // Simultaneous write and read return the old value
    cycle(1'b1, 1'b1, 8'h48, 32'h1234_0000, 4'h0);
    chk("wr_rd_old", {48'h0, up_data_rd}, {48'h0, 32'hA5A5_5A5A});
    cycle(1'b0, 1'b1, 8'h48, 32'h0, 4'h0);
    chk("wr_rd_new", {48'h0, up_data_rd}, {48'h0, 32'h1234_0000});

    // Snapshot and load
    rtc = {48'h1234_5678_9ABC, 32'h0000_0100};
    cycle(1'b1, 1'b0, 8'h04, 32'h3, 4'h0);
    chk("load_pulse", {79'h0, rtc_load}, 80'h1);
    rtc = 80'h0;
    cycle(1'b0, 1'b1, 8'h20, 32'h0, 4'h0);
    chk("load_one_cycle", {79'h0, rtc_load}, 80'h0);
    chk("tod_shi", {48'h0, up_data_rd}, {48'h0, 32'h1234});
    cycle(1'b0, 1'b1, 8'h24, 32'h0, 4'h0);
    chk("tod_slo", {48'h0, up_data_rd}, {48'h0, 32'h5678_9ABC});
    cycle(1'b0, 1'b1, 8'h28, 32'h0, 4'h0);
    chk("tod_ns", {48'h0, up_data_rd}, {48'h0, 32'h100});

    // Timestamp queue
    q.push_back({16'h0001, 32'h2, 32'h3});
    cycle(1'b0, 1'b1, 8'h34, 32'h0, 4'h0);
    chk("tsq_shi", {48'h0, up_data_rd}, {48'h0, 32'h1});
    chk("tsq_pop", {79'h0, ts_q_pop}, 80'h1);
    cycle(1'b0, 1'b1, 8'h38, 32'h0, 4'h0);
    chk("tsq_pop_once", {79'h0, ts_q_pop}, 80'h0);
    chk("tsq_slo", {48'h0, up_data_rd}, {48'h0, 32'h2});
    cycle(1'b0, 1'b1, 8'h3C, 32'h0, 4'h0);
    chk("tsq_ns", {48'h0, up_data_rd}, {48'h0, 32'h3});
    cycle(1'b0, 1'b1, 8'h34, 32'h0, 4'h0);
    chk("tsq_empty_rd", {48'h0, up_data_rd}, 80'h0);
    chk("tsq_empty_nopop", {79'h0, ts_q_pop}, 80'h0);
    cycle(1'b0, 1'b1, 8'h38, 32'h0, 4'h0);
    chk("tsq_shadow_kept", {48'h0, up_data_rd}, {48'h0, 32'h2});

    // Interrupts
    cycle(1'b1, 1'b0, 8'h44, 32'h2, 4'h0);
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h2);
    chk("irq_lag", {79'h0, irq}, 80'h0);
    cycle(1'b0, 1'b1, 8'h40, 32'h0, 4'h0);
    chk("irq_set", {79'h0, irq}, 80'h1);
    chk("irq_stat", {48'h0, up_data_rd}, {48'h0, 32'h2});
    cycle(1'b1, 1'b0, 8'h40, 32'h2, 4'h2);
    cycle(1'b0, 1'b1, 8'h40, 32'h0, 4'h0);
    chk("set_wins", {48'h0, up_data_rd}, {48'h0, 32'h2});
    cycle(1'b1, 1'b0, 8'h40, 32'h2, 4'h0);
    cycle(1'b0, 1'b1, 8'h40, 32'h0, 4'h0);
    chk("w1c_clear", {48'h0, up_data_rd}, 80'h0);
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    chk("irq_clear", {79'h0, irq}, 80'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      logic [3:0] ev;
      if ($urandom_range(0, 4) == 0) q.push_back({16'($urandom), $urandom, $urandom});
      rtc = {16'($urandom), $urandom, $urandom};
      a = ($urandom_range(0, 3) != 0) ? addrs[$urandom_range(0, 16)] : 8'($urandom);
      ev = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, a, $urandom, ev);
    end
    cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
